// File: rtl/td4x_core.sv
// td4x_core: parametrised TD4 execution core with fetch stall, subtract,
// call/return on a hardware return stack, and a sticky halt/error state.
module td4x_core #(
  parameter int DW = 4,
  parameter int AW = 4,
  parameter int SD = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW+3:0] op,
  input  logic          op_valid,
  input  logic [DW-1:0] gpi,
  output logic [DW-1:0] gpo,
  output logic [AW-1:0] ip,
  output logic          halted,
  output logic          err
);

  localparam int SPW = $clog2(SD + 1);
  localparam int IW  = (SD > 1) ? $clog2(SD) : 1;

  typedef enum logic {
    S_RUN,
    S_HALT
  } state_t;

  typedef enum logic [3:0] {
    OP_ADD_A  = 4'h0,
    OP_MOV_AB = 4'h1,
    OP_IN_A   = 4'h2,
    OP_MOV_AI = 4'h3,
    OP_MOV_BA = 4'h4,
    OP_ADD_B  = 4'h5,
    OP_IN_B   = 4'h6,
    OP_MOV_BI = 4'h7,
    OP_CALL   = 4'h8,
    OP_OUT_B  = 4'h9,
    OP_RET    = 4'hA,
    OP_OUT_I  = 4'hB,
    OP_HLT    = 4'hC,
    OP_SUB_A  = 4'hD,
    OP_JNC    = 4'hE,
    OP_JMP    = 4'hF
  } opcode_t;

  state_t          state;
  opcode_t         opc;
  logic [DW-1:0]   im;
  logic [AW-1:0]   tgt;
  logic [DW-1:0]   reg_a;
  logic [DW-1:0]   reg_b;
  logic            cflag;
  logic [SPW-1:0]  sp;
  logic [AW-1:0]   stk [2**IW];

  logic [DW:0]     sum_a;
  logic [DW:0]     sum_b;
  logic [DW:0]     diff_a;
  logic [AW-1:0]   ip_inc;
  logic [SPW-1:0]  sp_dec;
  logic            stk_full;
  logic            stk_empty;
  logic            exec;
  logic            push_en;

  assign opc       = opcode_t'(op[DW+3:DW]);
  assign im        = op[DW-1:0];
  assign tgt       = im[AW-1:0];

  always_comb begin
    sum_a     = {1'b0, reg_a} + {1'b0, im};
    sum_b     = {1'b0, reg_b} + {1'b0, im};
    // Bit DW of the widened difference is the borrow (set exactly when im > reg_a).
    diff_a    = {1'b0, reg_a} - {1'b0, im};
    ip_inc    = ip + AW'(1);
    sp_dec    = sp - SPW'(1);
    stk_full  = (sp == SPW'(SD));
    stk_empty = (sp == '0);
    exec      = (state == S_RUN) && op_valid;
    push_en   = exec && (opc == OP_CALL) && !stk_full;
  end

  // Stack storage needs no reset: entries above sp are never read.
  always_ff @(posedge clk) begin
    if (push_en) stk[sp[IW-1:0]] <= ip_inc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_RUN;
      ip     <= '0;
      gpo    <= '0;
      reg_a  <= '0;
      reg_b  <= '0;
      cflag  <= 1'b0;
      sp     <= '0;
      halted <= 1'b0;
      err    <= 1'b0;
    end else begin
      case (state)
        S_RUN: begin
          if (op_valid) begin
            cflag <= 1'b0;
            ip    <= ip_inc;
            case (opc)
              OP_ADD_A: begin
                reg_a <= sum_a[DW-1:0];
                cflag <= sum_a[DW];
              end
              OP_MOV_AB: reg_a <= reg_b;
              OP_IN_A:   reg_a <= gpi;
              OP_MOV_AI: reg_a <= im;
              OP_MOV_BA: reg_b <= reg_a;
              OP_ADD_B: begin
                reg_b <= sum_b[DW-1:0];
                cflag <= sum_b[DW];
              end
              OP_IN_B:   reg_b <= gpi;
              OP_MOV_BI: reg_b <= im;
              OP_CALL: begin
                if (stk_full) begin
                  ip     <= ip;
                  cflag  <= cflag;
                  err    <= 1'b1;
                  halted <= 1'b1;
                  state  <= S_HALT;
                end else begin
                  ip <= tgt;
                  sp <= sp + SPW'(1);
                end
              end
              OP_OUT_B:  gpo <= reg_b;
              OP_RET: begin
                if (stk_empty) begin
                  ip     <= ip;
                  cflag  <= cflag;
                  err    <= 1'b1;
                  halted <= 1'b1;
                  state  <= S_HALT;
                end else begin
                  ip <= stk[sp_dec[IW-1:0]];
                  sp <= sp_dec;
                end
              end
              OP_OUT_I:  gpo <= im;
              OP_HLT: begin
                ip     <= ip;
                halted <= 1'b1;
                state  <= S_HALT;
              end
              OP_SUB_A: begin
                reg_a <= diff_a[DW-1:0];
                cflag <= diff_a[DW];
              end
              OP_JNC: begin
                if (!cflag) ip <= tgt;
              end
              OP_JMP:    ip <= tgt;
              default:   ;
            endcase
          end
        end
        S_HALT: ;
        default: state <= S_HALT;
      endcase
    end
  end

endmodule

// File: tb/tb_td4x_core.sv
// Self-checking bench for td4x_core: constant vector table, hand sequences,
// and randomised programs checked against a queue-based behavioural model.
module tb_td4x_core;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic [7:0]  op0 = '0;
  logic        v0 = 1'b0;
  logic [3:0]  gpi0 = '0;
  logic [3:0]  gpo0;
  logic [3:0]  ip0;
  logic        h0, e0;

  logic [11:0] op1 = '0;
  logic        v1 = 1'b0;
  logic [7:0]  gpi1 = '0;
  logic [7:0]  gpo1;
  logic [5:0]  ip1;
  logic        h1, e1;

  td4x_core #(.DW(4), .AW(4), .SD(2)) u0 (
    .clk(clk), .rst_n(rst_n), .op(op0), .op_valid(v0), .gpi(gpi0),
    .gpo(gpo0), .ip(ip0), .halted(h0), .err(e0)
  );

  td4x_core #(.DW(8), .AW(6), .SD(4)) u1 (
    .clk(clk), .rst_n(rst_n), .op(op1), .op_valid(v1), .gpi(gpi1),
    .gpo(gpo1), .ip(ip1), .halted(h1), .err(e1)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Behavioural model state
  int m_dw, m_aw, m_sd;
  int m_a, m_b, m_c, m_ip, m_gpo;
  bit m_h, m_e;
  int m_stk[$];

  typedef struct {
    int inst;
    bit rst;
    int opc;
    int im;
    bit v;
    int ip;
    int gpo;
    int h;
    int e;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_out(input string tag, input int inst,
                           input int eip, input int egpo, input int eh, input int ee);
    chk({tag, ".ip"},     inst != 0 ? int'(ip1)  : int'(ip0),  eip);
    chk({tag, ".gpo"},    inst != 0 ? int'(gpo1) : int'(gpo0), egpo);
    chk({tag, ".halted"}, inst != 0 ? int'(h1)   : int'(h0),   eh);
    chk({tag, ".err"},    inst != 0 ? int'(e1)   : int'(e0),   ee);
  endtask

  task automatic cycle(input int inst, input int opc, input int im, input bit v);
    if (inst == 0) begin
      op0 = 8'((opc << 4) | (im & 15));
      v0  = v;
      v1  = 1'b0;
    end else begin
      op1 = 12'((opc << 8) | (im & 255));
      v1  = v;
      v0  = 1'b0;
    end
    gpi0 = 4'($urandom);
    gpi1 = 8'($urandom);
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_a = 0; m_b = 0; m_c = 0; m_ip = 0; m_gpo = 0;
    m_h = 1'b0; m_e = 1'b0;
    m_stk.delete();
  endtask

  task automatic do_reset(input int inst, input string tag);
    rst_n = 1'b0;
    #2;
    check_out(tag, inst, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic model_step(input int opc, input int im, input bit v, input int gpi);
    int md, ma, nxt, tgt, s;
    md  = (1 << m_dw) - 1;
    ma  = (1 << m_aw) - 1;
    nxt = (m_ip + 1) & ma;
    tgt = im & ma;
    if (m_h || !v) return;
    case (opc)
      0:  begin s = m_a + im; m_a = s & md; m_c = s >> m_dw; m_ip = nxt; end
      1:  begin m_a = m_b; m_c = 0; m_ip = nxt; end
      2:  begin m_a = gpi; m_c = 0; m_ip = nxt; end
      3:  begin m_a = im;  m_c = 0; m_ip = nxt; end
      4:  begin m_b = m_a; m_c = 0; m_ip = nxt; end
      5:  begin s = m_b + im; m_b = s & md; m_c = s >> m_dw; m_ip = nxt; end
      6:  begin m_b = gpi; m_c = 0; m_ip = nxt; end
      7:  begin m_b = im;  m_c = 0; m_ip = nxt; end
      8:  begin
            if (m_stk.size() >= m_sd) begin m_e = 1'b1; m_h = 1'b1; end
            else begin m_stk.push_back(nxt); m_ip = tgt; m_c = 0; end
          end
      9:  begin m_gpo = m_b; m_c = 0; m_ip = nxt; end
      10: begin
            if (m_stk.size() == 0) begin m_e = 1'b1; m_h = 1'b1; end
            else begin m_ip = m_stk.pop_back(); m_c = 0; end
          end
      11: begin m_gpo = im; m_c = 0; m_ip = nxt; end
      12: begin m_h = 1'b1; m_c = 0; end
      13: begin m_c = (im > m_a) ? 1 : 0; m_a = (m_a - im) & md; m_ip = nxt; end
      14: begin m_ip = (m_c == 0) ? tgt : nxt; m_c = 0; end
      default: begin m_ip = tgt; m_c = 0; end
    endcase
  endtask

  function automatic void add(input int inst, input bit rst, input int opc, input int im,
                              input bit v, input int eip, input int egpo, input int eh, input int ee);
    vecs.push_back('{inst, rst, opc, im, v, eip, egpo, eh, ee});
  endfunction

  function automatic void add_rst(input int inst);
    add(inst, 1'b1, 0, 0, 1'b0, 0, 0, 0, 0);
  endfunction

  initial begin
    // Reset then stall for five cycles, then the first real instruction.
    add_rst(0);
    for (int i = 0; i < 5; i++) add(0, 0, 3, 5, 0, 0, 0, 0, 0);
    add(0, 0, 3, 5, 1, 1, 0, 0, 0);
    // Carry loop: ADD overflows, JNC falls through; then no carry, JNC branches.
    add_rst(0);
    add(0, 0, 3, 1, 1, 1, 0, 0, 0);
    add(0, 0, 0, 15, 1, 2, 0, 0, 0);
    add(0, 0, 14, 0, 1, 3, 0, 0, 0);
    add(0, 0, 11, 9, 1, 4, 9, 0, 0);
    add(0, 0, 3, 1, 1, 5, 9, 0, 0);
    add(0, 0, 0, 1, 1, 6, 9, 0, 0);
    add(0, 0, 14, 0, 1, 0, 9, 0, 0);
    // SUB borrow: 3-5 = E with borrow, E-2 = C without.
    add_rst(0);
    add(0, 0, 3, 3, 1, 1, 0, 0, 0);
    add(0, 0, 13, 5, 1, 2, 0, 0, 0);
    add(0, 0, 14, 15, 1, 3, 0, 0, 0);
    add(0, 0, 4, 0, 1, 4, 0, 0, 0);
    add(0, 0, 9, 0, 1, 5, 14, 0, 0);
    add(0, 0, 13, 2, 1, 6, 14, 0, 0);
    add(0, 0, 14, 0, 1, 0, 14, 0, 0);
    add(0, 0, 4, 0, 1, 1, 14, 0, 0);
    add(0, 0, 9, 0, 1, 2, 12, 0, 0);
    // Call/return with SD=2, stalled CALL, then three-deep overflow.
    add_rst(0);
    add(0, 0, 3, 0, 1, 1, 0, 0, 0);
    add(0, 0, 3, 0, 1, 2, 0, 0, 0);
    add(0, 0, 8, 8, 1, 8, 0, 0, 0);
    add(0, 0, 11, 7, 1, 9, 7, 0, 0);
    add(0, 0, 10, 0, 1, 3, 7, 0, 0);
    add(0, 0, 8, 5, 0, 3, 7, 0, 0);
    add(0, 0, 8, 5, 1, 5, 7, 0, 0);
    add(0, 0, 8, 9, 1, 9, 7, 0, 0);
    add(0, 0, 8, 1, 1, 9, 7, 1, 1);
    add(0, 0, 3, 1, 1, 9, 7, 1, 1);
    add(0, 0, 11, 3, 1, 9, 7, 1, 1);
    // Underflow on empty stack.
    add_rst(0);
    add(0, 0, 10, 0, 1, 0, 0, 1, 1);
    add(0, 0, 15, 4, 1, 0, 0, 1, 1);
    // Wide instance: 8-bit carry at FF+1, targets from im[5:0], call/return.
    add_rst(1);
    add(1, 0, 3, 255, 1, 1, 0, 0, 0);
    add(1, 0, 0, 1, 1, 2, 0, 0, 0);
    add(1, 0, 14, 63, 1, 3, 0, 0, 0);
    add(1, 0, 11, 9, 1, 4, 9, 0, 0);
    add(1, 0, 3, 254, 1, 5, 9, 0, 0);
    add(1, 0, 0, 1, 1, 6, 9, 0, 0);
    add(1, 0, 14, 197, 1, 5, 9, 0, 0);
    add(1, 0, 8, 232, 1, 40, 9, 0, 0);
    add(1, 0, 11, 119, 1, 41, 119, 0, 0);
    add(1, 0, 10, 0, 1, 6, 119, 0, 0);

    @(posedge clk);
    #1;
    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].rst) do_reset(vecs[i].inst, $sformatf("tbl%0d.rst", i));
      else begin
        cycle(vecs[i].inst, vecs[i].opc, vecs[i].im, vecs[i].v);
        check_out($sformatf("tbl%0d", i), vecs[i].inst,
                  vecs[i].ip, vecs[i].gpo, vecs[i].h, vecs[i].e);
      end
    end

    // HLT at ip 6 holds for 10 cycles while op toggles; reset mid-HALT clears.
    do_reset(0, "hlt.rst");
    for (int i = 0; i < 6; i++) begin
      cycle(0, 3, 0, 1);
      check_out("hlt.pre", 0, i + 1, 0, 0, 0);
    end
    cycle(0, 12, 0, 1);
    check_out("hlt.enter", 0, 6, 0, 1, 0);
    for (int i = 0; i < 10; i++) begin
      cycle(0, $urandom_range(0, 15), $urandom_range(0, 15), 1'($urandom));
      check_out("hlt.hold", 0, 6, 0, 1, 0);
    end
    do_reset(0, "hlt.midrst");
    check_out("hlt.after", 0, 0, 0, 0, 0);

    // ip wraps from F to 0 with AW=4.
    for (int i = 0; i < 15; i++) cycle(0, 3, 0, 1);
    check_out("wrap.f", 0, 15, 0, 0, 0);
    cycle(0, 3, 0, 1);
    check_out("wrap.0", 0, 0, 0, 0, 0);

    // Randomised programs against the behavioural model, both instances.
    for (int inst = 0; inst < 2; inst++) begin
      m_dw = (inst != 0) ? 8 : 4;
      m_aw = (inst != 0) ? 6 : 4;
      m_sd = (inst != 0) ? 4 : 2;
      do_reset(inst, "rnd.rst");
      for (int n = 0; n < 800; n++) begin
        if ((m_h && $urandom_range(0, 5) == 0) || $urandom_range(0, 150) == 0) begin
          do_reset(inst, "rnd.rst");
        end else begin
          int opc, im;
          bit v;
          opc = $urandom_range(0, 15);
          if (opc == 12 && $urandom_range(0, 3) != 0) opc = 3;
          im  = $urandom_range(0, (1 << m_dw) - 1);
          v   = ($urandom_range(0, 4) != 0);
          cycle(inst, opc, im, v);
          model_step(opc, im, v, (inst != 0) ? int'(gpi1) : int'(gpi0));
          check_out($sformatf("rnd%0d.op%0h", inst, opc), inst, m_ip, m_gpo, m_h, m_e);
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
